// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: state encodings,
// default widths and the run-mode selection helper.
package pc_pkg;

    localparam int PC_WIDTH_DEF  = 32;
    localparam int PC_STEP_DEF   = 4;
    localparam int CNT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } pc_state_t;

    // Free-running versus single-step operating state, chosen by the debug mode input.
    function automatic pc_state_t run_state(input logic step_mode);
        return step_mode ? ST_STEP_WAIT : ST_RUN;
    endfunction

endpackage

// File: rtl/pc_adv_counter.sv
// Counts PC advances; wraps silently at 2^WIDTH, cleared by reset or soft clear.
module pc_adv_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(negedge i_clk) begin
        if (i_reset || i_clear)
            o_count <= '0;
        else if (i_enable)
            o_count <= o_count + WIDTH'(1);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/STEP_WAIT/HALTED control FSM with
// redirect, halt/resume, single-step and soft clear; state changes on the falling edge.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  PC_STEP      = PC_STEP_DEF,
    parameter int                  CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_halt,
    input  logic                 i_resume,
    input  logic                 i_clear,
    input  logic                 i_redirect,
    input  logic [PC_WIDTH-1:0]  i_redirect_pc,
    input  logic                 i_step_mode,
    input  logic                 i_step,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic                 o_pc_valid,
    output logic                 o_halted,
    output logic [1:0]           o_state,
    output logic                 o_misaligned,
    output logic [CNT_WIDTH-1:0] o_adv_count
);

    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(STEP - PC_WIDTH'(1));

    pc_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                misaligned_q, misaligned_d;
    logic                cnt_inc;
    logic                advance;

    assign advance = i_enable && !i_stall &&
                     ((state_q == ST_RUN) || ((state_q == ST_STEP_WAIT) && i_step));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        cnt_inc      = 1'b0;

        if (i_clear) begin
            state_d      = ST_IDLE;
            pc_d         = RESET_VECTOR;
            misaligned_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pc_d = RESET_VECTOR;
                    if (i_enable)
                        state_d = run_state(i_step_mode);
                end
                ST_RUN, ST_STEP_WAIT: begin
                    if (i_enable) begin
                        // Mode tracks i_step_mode every enabled cycle; a halt overrides it.
                        state_d = run_state(i_step_mode);
                        if (advance) begin
                            if (i_halt) begin
                                state_d = ST_HALTED;
                            end else if (i_redirect) begin
                                pc_d    = i_redirect_pc & ALIGN_MASK;
                                cnt_inc = 1'b1;
                                if (|(i_redirect_pc & ~ALIGN_MASK))
                                    misaligned_d = 1'b1;
                            end else begin
                                pc_d    = pc_q + STEP;
                                cnt_inc = 1'b1;
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    if (i_enable && i_resume) begin
                        state_d = run_state(i_step_mode);
                        pc_d    = pc_q + STEP;
                        cnt_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    pc_adv_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_adv_counter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_clear),
        .i_enable (cnt_inc),
        .o_count  (o_adv_count)
    );

    assign o_pc         = pc_q;
    assign o_state      = state_q;
    assign o_halted     = (state_q == ST_HALTED);
    assign o_misaligned = misaligned_q;
    assign o_pc_valid   = (state_q == ST_RUN) || ((state_q == ST_STEP_WAIT) && i_step);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of program counter.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset, clear and restart.
REQ-003 SHALL have parameter PC_STEP, default 4, sequential increment; power of two, at least 1.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, width of advance counter.
REQ-005 SHALL have one clock and a synchronous, active-high reset: i_clk  in  1  clock, all state updates on falling edge.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_enable  in  1  global advance enable; low freezes PC and state.
REQ-008 i_stall  in  1  hazard stall; PC held.
REQ-009 i_halt  in  1  halt request from decode.
REQ-010 i_resume  in  1  leave HALTED, continue at PC+PC_STEP.
REQ-011 i_clear  in  1  soft restart to RESET_VECTOR.
REQ-012 i_redirect  in  1  branch/jump taken.
REQ-013 i_redirect_pc  in  PC_WIDTH  redirect target.
REQ-014 i_step_mode  in  1  single-step debug mode.
REQ-015 i_step  in  1  one-cycle pulse granting one advance in step mode.
REQ-016 o_pc  out  PC_WIDTH  current PC.
REQ-017 o_pc_valid  out  1  high in RUN, and in STEP_WAIT on a step-pulse cycle.
REQ-018 o_halted  out  1  high in HALTED.
REQ-019 o_state  out  2  encoded state.
REQ-020 o_misaligned  out  1  sticky misaligned-redirect flag.
REQ-021 o_adv_count  out  CNT_WIDTH  count of PC advances.

Function
REQ-022 States SHALL be IDLE=0, RUN=1, STEP_WAIT=2, HALTED=3.
REQ-023 IDLE: PC=RESET_VECTOR; next state RUN if i_step_mode low, else STEP_WAIT.
REQ-024 An advance SHALL be permitted in RUN when i_enable and not i_stall, or in STEP_WAIT when i_enable, not i_stall and i_step.
REQ-025 Permitted advance with i_halt: PC held, state to HALTED, counter unchanged.
REQ-026 Else permitted advance with i_redirect: PC = i_redirect_pc with log2(PC_STEP) LSBs forced to zero; counter +1.
REQ-027 Else permitted advance: PC = PC + PC_STEP modulo 2^PC_WIDTH (wraps to 0); counter +1.
REQ-028 Priority per cycle SHALL be i_reset > i_clear > i_halt > i_redirect > increment; i_stall or no permission holds PC and counter.
REQ-029 o_misaligned SHALL set on any applied redirect with nonzero dropped LSBs; stays set until reset or clear.
REQ-030 RUN and STEP_WAIT SHALL switch to each other each cycle i_step_mode differs, independent of advance.
REQ-031 HALTED: PC held; i_resume with i_enable moves to RUN/STEP_WAIT per i_step_mode and PC = PC + PC_STEP; i_halt ignored while HALTED.
REQ-032 i_clear SHALL set PC=RESET_VECTOR, state IDLE, counter 0, o_misaligned 0, one cycle after assertion, from any state.
REQ-033 o_adv_count SHALL wrap at 2^CNT_WIDTH silently.
REQ-034 All outputs SHALL be registered or decoded from state only; latency input-to-o_pc one falling edge.

Reset
REQ-035 i_reset SHALL give o_pc=RESET_VECTOR, state IDLE, o_pc_valid 0, o_halted 0, o_misaligned 0, o_adv_count 0 after the next falling edge.
REQ-036 Reset mid-halt or mid-step SHALL discard pending resume/step.

Structure
REQ-037 State encodings and PC_STEP/width defaults SHALL live in shared package pc_pkg.
REQ-038 One sub-module pc_adv_counter (enable, clear, wrap) is natural; remainder single FSM plus datapath.

Verification
REQ-039 Reset, run 4 cycles enabled -> o_pc 0,4,8,12; o_adv_count 3 after third advance.
REQ-040 Redirect to 0x103 at PC 0x10 -> o_pc 0x100, o_misaligned 1 until i_clear.
REQ-041 Halt at PC 0x20 with redirect and stall low -> HALTED, o_pc 0x20; resume -> o_pc 0x24, RUN.
REQ-042 Step mode, three i_step pulses spaced 5 cycles -> o_pc advances exactly 3 times, held between.
REQ-043 PC_WIDTH=8, PC at 0xFC, advance -> o_pc 0x00; CNT_WIDTH=4 wraps 15->0.
REQ-044 i_clear and i_halt same cycle in RUN -> IDLE, o_pc RESET_VECTOR, counter 0.
